// File: rtl/retire_if.sv
// Commit-side bundle between the ROB head / store queue and retire_ctrl.
// master = ROB/store-queue side, slave = the retire sequencer.
interface retire_if #(
  parameter int TAG_W  = 6,
  parameter int AREG_W = 5,
  parameter int CNT_W  = 32
);
  logic              rob_head_vld_i;
  logic              rob_head_done_i;
  logic [TAG_W-1:0]  rob_head_t_i;
  logic [TAG_W-1:0]  rob_head_told_i;
  logic [AREG_W-1:0] rob_head_dest_i;
  logic              rob_head_br_flag_i;
  logic              rob_head_br_pretaken_i;
  logic              rob_head_br_taken_i;
  logic              rob_head_wr_mem_i;
  logic              rob_head_halt_i;
  logic              sq_commit_ack_i;

  logic              sq_commit_req_o;
  logic              rob_retire_en_o;
  logic              fl_release_en_o;
  logic [TAG_W-1:0]  fl_release_tag_o;
  logic              amap_wr_en_o;
  logic [TAG_W-1:0]  amap_tag_o;
  logic [AREG_W-1:0] amap_dest_o;
  logic              br_recovery_en_o;
  logic              halt_o;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  retire_cnt_o;

  modport master (
    output rob_head_vld_i, rob_head_done_i, rob_head_t_i, rob_head_told_i,
           rob_head_dest_i, rob_head_br_flag_i, rob_head_br_pretaken_i,
           rob_head_br_taken_i, rob_head_wr_mem_i, rob_head_halt_i,
           sq_commit_ack_i,
    input  sq_commit_req_o, rob_retire_en_o, fl_release_en_o, fl_release_tag_o,
           amap_wr_en_o, amap_tag_o, amap_dest_o, br_recovery_en_o, halt_o,
           state_o, retire_cnt_o
  );

  modport slave (
    input  rob_head_vld_i, rob_head_done_i, rob_head_t_i, rob_head_told_i,
           rob_head_dest_i, rob_head_br_flag_i, rob_head_br_pretaken_i,
           rob_head_br_taken_i, rob_head_wr_mem_i, rob_head_halt_i,
           sq_commit_ack_i,
    output sq_commit_req_o, rob_retire_en_o, fl_release_en_o, fl_release_tag_o,
           amap_wr_en_o, amap_tag_o, amap_dest_o, br_recovery_en_o, halt_o,
           state_o, retire_cnt_o
  );
endinterface

// File: rtl/retire_ctrl.sv
// In-order commit sequencer for the ROB head; drives pop, free-list, arch-map and recovery strobes.
// Optional RETIRE_STALL_CNT_EN adds stall_cnt_o (cycles with a valid head but no retire).
//
// state   | meaning
// RUN     | examine head, retire when ready
// ST_WAIT | store commit requested, waiting for store-queue ack
// RECOVER | one-cycle misprediction recovery strobe
// HALT    | halted until reset
module retire_ctrl #(
  parameter int TAG_W  = 6,
  parameter int AREG_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RETIRE_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
`endif
  retire_if.slave          bus
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam logic [AREG_W-1:0] ZERO_REG = {AREG_W{1'b1}};

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] retire_cnt;
  logic             ready, mispredict;
  logic             retire, commit_req, recovery;
  logic             has_dest;

  assign ready      = bus.rob_head_vld_i & bus.rob_head_done_i;
  assign mispredict = bus.rob_head_br_flag_i &
                      (bus.rob_head_br_taken_i != bus.rob_head_br_pretaken_i);
  assign has_dest   = (bus.rob_head_dest_i != ZERO_REG);

  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    commit_req = 1'b0;
    recovery   = 1'b0;
    case (state)
      RUN: begin
        if (ready) begin
          if (bus.rob_head_wr_mem_i) begin
            commit_req = 1'b1;
            // Ack in the request cycle commits the store without visiting ST_WAIT.
            if (bus.sq_commit_ack_i) retire = 1'b1;
            else                     state_nxt = ST_WAIT;
          end else if (mispredict) begin
            retire    = 1'b1;
            state_nxt = RECOVER;
          end else if (bus.rob_head_halt_i) begin
            retire    = 1'b1;
            state_nxt = HALT;
          end else begin
            retire    = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        commit_req = 1'b1;
        if (bus.sq_commit_ack_i) begin
          retire    = 1'b1;
          state_nxt = RUN;
        end
      end
      RECOVER: begin
        recovery  = 1'b1;
        state_nxt = RUN;
      end
      default: begin
        state_nxt = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      retire_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retire_cnt <= retire_cnt + 1'b1;
    end
  end

`ifdef RETIRE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (((state == RUN) || (state == ST_WAIT)) && bus.rob_head_vld_i && !retire) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`endif

  // Strobes are forced low while rst is held so nothing downstream advances.
  always_comb begin
    bus.rob_retire_en_o  = retire & ~rst;
    bus.sq_commit_req_o  = commit_req & ~rst;
    bus.br_recovery_en_o = recovery & ~rst;
    bus.fl_release_en_o  = retire & has_dest & ~rst;
    bus.amap_wr_en_o     = retire & has_dest & ~rst;
    bus.fl_release_tag_o = bus.rob_head_told_i;
    bus.amap_tag_o       = bus.rob_head_t_i;
    bus.amap_dest_o      = bus.rob_head_dest_i;
    bus.halt_o           = (state == HALT);
    bus.state_o          = state;
    bus.retire_cnt_o     = retire_cnt;
  end

endmodule
